// File: rtl/flash_key_sched.sv
// Key-driven scheduler for a flash engine: erase/write/read requests, watchdog and guard gap.
// Define FLASH_KEY_PEND_EN to queue every key pulse; otherwise only one request is held while idle.
module flash_key_sched #(
    parameter logic [25:0] TIMEOUT_MAX = 26'd49_999_999,
    parameter logic [15:0] GAP_MAX     = 16'd49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_erase,
    input  logic       key_write,
    input  logic       key_read,
    input  logic       op_done,
    output logic       op_start,
    output logic [1:0] op_sel,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpErase = 2'b01;
    localparam logic [1:0] OpWrite = 2'b10;
    localparam logic [1:0] OpRead  = 2'b11;

    state_e      state_q;
    logic [2:0]  pend_q;     // {read, write, erase}
    logic [2:0]  pend_d;
    logic [25:0] wdog_q;
    logic [15:0] gap_q;

    logic [2:0]  key_vec;
    logic [2:0]  pend_pick;
    logic [2:0]  pend_clr;
    logic [2:0]  pend_set;
    logic        start_go;
    logic        wdog_hit;
    logic        gap_hit;

    // Fixed priority erase > write > read, returned one-hot.
    function automatic logic [2:0] prio_onehot(input logic [2:0] v);
        if (v[0]) begin
            return 3'b001;
        end else if (v[1]) begin
            return 3'b010;
        end else if (v[2]) begin
            return 3'b100;
        end
        return 3'b000;
    endfunction

    function automatic logic [1:0] onehot_to_op(input logic [2:0] oh);
        case (oh)
            3'b001:  return OpErase;
            3'b010:  return OpWrite;
            3'b100:  return OpRead;
            default: return OpNone;
        endcase
    endfunction

    assign key_vec   = {key_read, key_write, key_erase};
    assign pend_pick = prio_onehot(pend_q);
    assign start_go  = (state_q == StIdle) && (pend_q != 3'b000);
    assign pend_clr  = start_go ? pend_pick : 3'b000;
    assign wdog_hit  = (wdog_q == TIMEOUT_MAX);
    assign gap_hit   = (gap_q == GAP_MAX);

`ifdef FLASH_KEY_PEND_EN
    assign pend_set = key_vec;
`else
    logic [2:0] key_pick;
    assign key_pick = prio_onehot(key_vec);
    // Only an empty, idle scheduler accepts a request; everything else is dropped.
    assign pend_set = ((state_q == StIdle) && (pend_q == 3'b000)) ? key_pick : 3'b000;
`endif

    // A key arriving on the edge that services the same bit is a fresh request and survives.
    assign pend_d = (pend_q & ~pend_clr) | pend_set;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            pend_q      <= 3'b000;
            wdog_q      <= '0;
            gap_q       <= '0;
            op_start    <= 1'b0;
            op_sel      <= OpNone;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            op_start    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_go) begin
                        state_q  <= StStart;
                        op_sel   <= onehot_to_op(pend_pick);
                        op_start <= 1'b1;
                        busy     <= 1'b1;
                        wdog_q   <= '0;
                        gap_q    <= '0;
                    end
                end
                StStart: begin
                    state_q <= StWait;
                    wdog_q  <= '0;
                    gap_q   <= '0;
                end
                StWait: begin
                    if (op_done) begin
                        state_q <= StGap;
                        wdog_q  <= '0;
                        gap_q   <= '0;
                    end else if (wdog_hit) begin
                        state_q     <= StGap;
                        timeout_err <= 1'b1;
                        wdog_q      <= '0;
                        gap_q       <= '0;
                    end else if (wdog_q != '1) begin
                        wdog_q <= wdog_q + 26'd1;
                    end
                end
                StGap: begin
                    if (gap_hit) begin
                        state_q <= StIdle;
                        op_sel  <= OpNone;
                        busy    <= 1'b0;
                        wdog_q  <= '0;
                        gap_q   <= '0;
                    end else if (gap_q != '1) begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    op_sel  <= OpNone;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_key_sched.sv
// Directed bench for flash_key_sched with TIMEOUT_MAX=100, GAP_MAX=4.
`timescale 1ns/1ps
module tb_flash_key_sched;

`ifdef FLASH_KEY_PEND_EN
    localparam logic PEND = 1'b1;
`else
    localparam logic PEND = 1'b0;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_erase = 1'b0;
    logic       key_write = 1'b0;
    logic       key_read  = 1'b0;
    logic       op_done   = 1'b0;
    logic       op_start;
    logic [1:0] op_sel;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;
    int cnt;

    flash_key_sched #(
        .TIMEOUT_MAX(26'd100),
        .GAP_MAX    (16'd4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_erase  (key_erase),
        .key_write  (key_write),
        .key_read   (key_read),
        .op_done    (op_done),
        .op_start   (op_start),
        .op_sel     (op_sel),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Key pulse in the current cycle; ends in the START cycle two cycles later.
    task automatic launch(input string tag, input logic e, input logic w, input logic r,
                          input logic [1:0] sel);
        key_erase = e;
        key_write = w;
        key_read  = r;
        step();
        key_erase = 1'b0;
        key_write = 1'b0;
        key_read  = 1'b0;
        check({tag, "_lat1"}, op_start, 1'b0);
        step();
        check({tag, "_start"}, op_start, 1'b1);
        check({tag, "_sel"}, op_sel, sel);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    // From START: op_done in the third WAIT cycle, then five GAP cycles; ends in IDLE.
    task automatic finish_op(input string tag, input logic wkey);
        step();
        check({tag, "_w0"}, op_start, 1'b0);
        key_write = wkey;
        step();
        key_write = 1'b0;
        step();
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        check({tag, "_gap"}, busy, 1'b1);
        repeat (4) step();
        check({tag, "_gap4"}, busy, 1'b1);
        step();
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_selz"}, op_sel, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_start", op_start, 1'b0);
        check("rst_sel", op_sel, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_terr", timeout_err, 1'b0);
        sys_rst_n = 1'b1;
        repeat (5) step();

        // Single read with op_done seven cycles into WAIT
        launch("rd", 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        check("rd_w0", op_start, 1'b0);
        check("rd_w0sel", op_sel, 2'b11);
        repeat (7) step();
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        check("rd_g0", busy, 1'b1);
        check("rd_g0sel", op_sel, 2'b11);
        repeat (4) step();
        check("rd_g4", busy, 1'b1);
        step();
        check("rd_idle", busy, 1'b0);
        check("rd_selz", op_sel, 2'b00);
        repeat (3) step();

        // Simultaneous keys: erase first, the rest only when queuing is enabled
        launch("pri", 1'b1, 1'b1, 1'b1, 2'b01);
        finish_op("pri_e", 1'b0);
        step();
        check("pri_2start", op_start, PEND);
        check("pri_2sel", op_sel, PEND ? 2'b10 : 2'b00);
`ifdef FLASH_KEY_PEND_EN
        finish_op("pri_w", 1'b0);
        step();
        check("pri_3start", op_start, 1'b1);
        check("pri_3sel", op_sel, 2'b11);
        finish_op("pri_r", 1'b0);
        step();
`endif
        check("pri_end", op_start, 1'b0);
        repeat (3) step();

        // Write key during WAIT: dropped, or exactly one extra write when queuing
        launch("drp", 1'b0, 1'b0, 1'b1, 2'b11);
        finish_op("drp", 1'b1);
        step();
        check("drp_xstart", op_start, PEND);
        check("drp_xsel", op_sel, PEND ? 2'b10 : 2'b00);
`ifdef FLASH_KEY_PEND_EN
        finish_op("drp_x", 1'b0);
        step();
`endif
        check("drp_end", op_start, 1'b0);
        repeat (3) step();

        // Watchdog expiry: pulse 101 cycles after WAIT entry
        launch("to", 1'b1, 1'b0, 1'b0, 2'b01);
        step();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt += int'(timeout_err);
        end
        check("to_early", cnt, 0);
        step();
        check("to_pulse", timeout_err, 1'b1);
        check("to_gapbusy", busy, 1'b1);
        step();
        check("to_once", timeout_err, 1'b0);
        repeat (4) step();
        check("to_idle", busy, 1'b0);
        check("to_selz", op_sel, 2'b00);
        repeat (3) step();

        // op_done in START ignored; op_done on the expiry cycle beats the watchdog
        launch("tie", 1'b0, 1'b1, 1'b0, 2'b10);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        repeat (10) step();
        check("ign_start", busy, 1'b1);
        check("ign_sel", op_sel, 2'b10);
        repeat (90) step();
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        check("tie_noterr", timeout_err, 1'b0);
        check("tie_gap", busy, 1'b1);
        step();
        check("tie_noterr2", timeout_err, 1'b0);
        repeat (4) step();
        check("tie_idle", busy, 1'b0);
        repeat (3) step();

        // Reset in WAIT with read and write pending
        launch("rst", 1'b1, 1'b0, 1'b0, 2'b01);
        step();
        key_read  = 1'b1;
        key_write = 1'b1;
        step();
        key_read  = 1'b0;
        key_write = 1'b0;
        step();
        sys_rst_n = 1'b0;
        #1;
        check("rstw_start", op_start, 1'b0);
        check("rstw_sel", op_sel, 2'b00);
        check("rstw_busy", busy, 1'b0);
        check("rstw_terr", timeout_err, 1'b0);
        step();
        sys_rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(op_start) + int'(busy);
        end
        check("rstw_quiet", cnt, 0);
        launch("post", 1'b0, 1'b0, 1'b1, 2'b11);
        finish_op("post", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
